// File: rtl/imem_pkg.sv
// Shared constants and FSM state encoding for the instruction-memory loader.
// State values are plain localparams so older tools can consume the package.
package imem_pkg;

    localparam int MEM_BYTES_DEF = 256;
    localparam int ADDR_W_DEF    = 8;
    localparam int WORD_BYTES    = 4;

    typedef logic [2:0] imem_state_t;

    localparam imem_state_t IDLE = 3'd0;
    localparam imem_state_t WAIT = 3'd1;
    localparam imem_state_t B0   = 3'd2;
    localparam imem_state_t B1   = 3'd3;
    localparam imem_state_t B2   = 3'd4;
    localparam imem_state_t B3   = 3'd5;
    localparam imem_state_t FIN  = 3'd6;

endpackage

// File: rtl/imem_byte_serializer.sv
// Splits a latched 32-bit word into four consecutive byte writes, LSB first,
// at ascending addresses; o_done marks the cycle carrying the last byte.
module imem_byte_serializer
    import imem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [31:0]       i_word,
    input  logic [ADDR_W:0]   i_base,
    output logic              o_we,
    output logic [ADDR_W:0]   o_addr,
    output logic [7:0]        o_wdata,
    output logic              o_done
);

    logic [31:0]     r_word;
    logic [1:0]      r_idx;
    logic            r_we;
    logic [ADDR_W:0] r_addr;
    logic [7:0]      r_wdata;
    logic [1:0]      w_idx_nxt;
    logic [7:0]      w_byte_nxt;

    assign w_idx_nxt = r_idx + 2'd1;

    always_comb begin
        w_byte_nxt = r_word[7:0];
        case (w_idx_nxt)
            2'd1:    w_byte_nxt = r_word[15:8];
            2'd2:    w_byte_nxt = r_word[23:16];
            2'd3:    w_byte_nxt = r_word[31:24];
            default: w_byte_nxt = r_word[7:0];
        endcase
    end

    // Reset drops r_we immediately, so a half-written word is abandoned.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_word  <= '0;
            r_idx   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (i_start) begin
            r_word  <= i_word;
            r_idx   <= '0;
            r_we    <= 1'b1;
            r_addr  <= i_base;
            r_wdata <= i_word[7:0];
        end else if (r_we) begin
            if (r_idx == 2'd3) begin
                r_we <= 1'b0;
            end else begin
                r_idx   <= w_idx_nxt;
                r_addr  <= r_addr + (ADDR_W+1)'(1);
                r_wdata <= w_byte_nxt;
            end
        end
    end

    assign o_we    = r_we;
    assign o_addr  = r_addr;
    assign o_wdata = r_wdata;
    assign o_done  = r_we && (r_idx == 2'd3);

endmodule

// File: rtl/imem_load_ctrl.sv
// Program loader and fetch/load arbiter for the byte-wide instruction memory.
// Optional running XOR checksum output enabled by IMEM_LOAD_CSUM_EN.
module imem_load_ctrl
    import imem_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int BASE_ADDR = 0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              load_start,
    input  logic              load_last,
    input  logic              load_valid,
    input  logic [31:0]       load_data,
    output logic              load_ready,
    input  logic [31:0]       pc,
    output logic [31:0]       mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    output logic              cpu_stall,
    output logic              load_done,
    output logic              load_ovf,
`ifdef IMEM_LOAD_CSUM_EN
    output logic [31:0]       load_csum,
`endif
    output logic [ADDR_W-2:0] word_count
);

    // Pointer is one bit wider than the address so "full" is distinct from 0.
    localparam logic [ADDR_W:0] PTR_FULL = (ADDR_W+1)'(MEM_BYTES);
    localparam logic [ADDR_W:0] PTR_BASE = (ADDR_W+1)'(BASE_ADDR);
    localparam logic [ADDR_W:0] PTR_STEP = (ADDR_W+1)'(WORD_BYTES);

    imem_state_t       r_state;
    imem_state_t       w_state_nxt;
    logic [ADDR_W:0]   r_ptr;
    logic              r_last;
    logic [ADDR_W-2:0] r_word_count;
    logic              r_load_ovf;
    logic              r_load_ready;
    logic              r_cpu_stall;
    logic              r_load_done;
    logic              w_hs;
    logic              w_full;
    logic              w_ser_start;
    logic              w_ser_we;
    logic [ADDR_W:0]   w_ser_addr;
    logic [7:0]        w_ser_wdata;
    logic              w_ser_done;

    assign w_hs        = r_load_ready && load_valid;
    assign w_full      = (r_ptr == PTR_FULL);
    assign w_ser_start = w_hs && !w_full;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (load_start) w_state_nxt = WAIT;
            WAIT:    if (w_hs) w_state_nxt = w_full ? FIN : B0;
            B0:      w_state_nxt = B1;
            B1:      w_state_nxt = B2;
            B2:      w_state_nxt = B3;
            B3:      if (w_ser_done) w_state_nxt = r_last ? FIN : WAIT;
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state      <= IDLE;
            r_ptr        <= PTR_BASE;
            r_last       <= 1'b0;
            r_word_count <= '0;
            r_load_ovf   <= 1'b0;
            r_load_ready <= 1'b0;
            r_cpu_stall  <= 1'b0;
            r_load_done  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_load_ready <= (w_state_nxt == WAIT);
            r_cpu_stall  <= (w_state_nxt != IDLE);
            r_load_done  <= (w_state_nxt == FIN);
            if (r_state == IDLE && load_start) begin
                r_ptr        <= PTR_BASE;
                r_word_count <= '0;
                r_load_ovf   <= 1'b0;
            end else if (w_hs) begin
                r_last <= load_last;
                if (w_full) r_load_ovf <= 1'b1;
            end else if (r_state == B3 && w_ser_done) begin
                r_ptr        <= r_ptr + PTR_STEP;
                r_word_count <= r_word_count + (ADDR_W-1)'(1);
            end
        end
    end

    imem_byte_serializer #(
        .ADDR_W (ADDR_W)
    ) u_ser (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_start (w_ser_start),
        .i_word  (load_data),
        .i_base  (r_ptr),
        .o_we    (w_ser_we),
        .o_addr  (w_ser_addr),
        .o_wdata (w_ser_wdata),
        .o_done  (w_ser_done)
    );

    // The CPU owns the address port whenever no session is running.
    always_comb begin
        if (r_state == IDLE) mem_addr = pc;
        else                 mem_addr = 32'(w_ser_addr);
    end

    assign mem_we     = w_ser_we;
    assign mem_wdata  = w_ser_wdata;
    assign load_ready = r_load_ready;
    assign cpu_stall  = r_cpu_stall;
    assign load_done  = r_load_done;
    assign load_ovf   = r_load_ovf;
    assign word_count = r_word_count;

`ifdef IMEM_LOAD_CSUM_EN
    logic [31:0] r_csum;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_csum <= '0;
        end else if (r_state == IDLE && load_start) begin
            r_csum <= '0;
        end else if (w_hs) begin
            r_csum <= r_csum ^ load_data;
        end
    end

    assign load_csum = r_csum;
`endif

endmodule
